// File: rtl/blinker_pkg.sv
// Shared types and constants for the blinker sequencing engine.
package blinker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd3
    } state_t;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_INV     = 2;
    localparam int CTRL_DIR     = 3;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_COUNT   = 2'd3;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_DONE_BIT  = 2;
    localparam int STAT_STEPS_LSB = 16;

    localparam logic [15:0] STEPS_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == STEPS_MAX) begin
            sat_inc16 = STEPS_MAX;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/blinker_prescaler.sv
// Step-rate divider: tick fires on the last count of each period; period 0 behaves as 1.
module blinker_prescaler
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] period,
    input  logic        clear,
    input  logic        run,
    output logic        tick
);

    logic [31:0] cnt_r;
    logic [31:0] last_s;

    assign last_s = (period == 32'd0) ? 32'd0 : (period - 32'd1);
    assign tick   = run && !clear && (cnt_r == last_s);

    // Free-running counter, held at zero while stopped or cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 32'd0;
        end else if (clear || !run || tick) begin
            cnt_r <= 32'd0;
        end else begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

endmodule

// File: rtl/blinker_core.sv
// Blinker sequencing engine: rotates an LED pattern at a programmable rate
// in free-running or one-shot mode and reports a status word.
module blinker_core
    import blinker_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int NUM_LEDS             = 8
)
(
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0] ctrl_reg,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0] period_reg,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0] pattern_reg,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0] count_reg,
    input  logic                            cfg_wr,
    input  logic [1:0]                      cfg_addr,
    output logic [NUM_LEDS-1:0]             leds,
    output logic                            step_tick,
    output logic [C_S00_AXI_DATA_WIDTH-1:0] status
);

    state_t                          state_r;
    logic [NUM_LEDS-1:0]             pattern_r;
    logic [15:0]                     steps_r;
    logic                            en_q_r;
    logic                            reload_r;
    logic                            per_wr_r;
    logic                            step_tick_r;
    logic [NUM_LEDS-1:0]             leds_r;
    logic [C_S00_AXI_DATA_WIDTH-1:0] status_r;

    logic                            tick_s;
    logic [15:0]                     steps_inc_s;
    logic [C_S00_AXI_DATA_WIDTH-1:0] steps_ext_s;
    logic [C_S00_AXI_DATA_WIDTH-1:0] status_s;

    function automatic logic [NUM_LEDS-1:0] rotate(input logic [NUM_LEDS-1:0] p,
                                                   input logic right);
        if (right) begin
            rotate = (p >> 1) | (p << (NUM_LEDS - 1));
        end else begin
            rotate = (p << 1) | (p >> (NUM_LEDS - 1));
        end
    endfunction

    // Register writes act one cycle after the strobe, once the slave register holds the new value.
    blinker_prescaler u_prescaler (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .period(period_reg[31:0]),
        .clear (reload_r || per_wr_r),
        .run   (state_r == RUN),
        .tick  (tick_s)
    );

    assign steps_inc_s = sat_inc16(steps_r);
    assign steps_ext_s = C_S00_AXI_DATA_WIDTH'(steps_inc_s);

    // Status word assembled from the registered state; it trails the state by one cycle.
    always_comb begin
        status_s                                   = '0;
        status_s[STAT_STATE_LSB +: 2]              = state_r;
        status_s[STAT_DONE_BIT]                    = (state_r == DONE);
        status_s[STAT_STEPS_LSB +: 16]             = steps_r;
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_r     <= IDLE;
            pattern_r   <= '0;
            steps_r     <= 16'd0;
            en_q_r      <= 1'b1;   // enable held across reset must not look like a rising edge
            reload_r    <= 1'b0;
            per_wr_r    <= 1'b0;
            step_tick_r <= 1'b0;
            leds_r      <= '0;
            status_r    <= '0;
        end else begin
            en_q_r      <= ctrl_reg[CTRL_EN];
            reload_r    <= cfg_wr && (cfg_addr == REG_PATTERN);
            per_wr_r    <= cfg_wr && (cfg_addr == REG_PERIOD);
            step_tick_r <= 1'b0;
            status_r    <= status_s;
            if ((state_r == RUN) || (state_r == DONE)) begin
                leds_r <= pattern_r ^ {NUM_LEDS{ctrl_reg[CTRL_INV]}};
            end else begin
                leds_r <= '0;
            end

            case (state_r)
                IDLE: begin
                    if (ctrl_reg[CTRL_EN] && !en_q_r) begin
                        state_r   <= RUN;
                        pattern_r <= pattern_reg[NUM_LEDS-1:0];
                        steps_r   <= 16'd0;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                RUN: begin
                    if (!ctrl_reg[CTRL_EN]) begin
                        state_r   <= IDLE;
                        pattern_r <= '0;
                        steps_r   <= 16'd0;
                    end else if (ctrl_reg[CTRL_ONESHOT] && (count_reg == '0)) begin
                        state_r   <= DONE;
                    end else if (reload_r) begin
                        pattern_r <= pattern_reg[NUM_LEDS-1:0];
                    end else if (tick_s) begin
                        pattern_r   <= rotate(pattern_r, ctrl_reg[CTRL_DIR]);
                        steps_r     <= steps_inc_s;
                        step_tick_r <= 1'b1;
                        if (ctrl_reg[CTRL_ONESHOT] && (steps_ext_s >= count_reg)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        state_r   <= RUN;
                    end
                end
                DONE: begin
                    if (!ctrl_reg[CTRL_EN]) begin
                        state_r   <= IDLE;
                        pattern_r <= '0;
                        steps_r   <= 16'd0;
                    end else begin
                        state_r   <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pattern_r <= '0;
                    steps_r   <= 16'd0;
                end
            endcase
        end
    end

    assign leds      = leds_r;
    assign step_tick = step_tick_r;
    assign status    = status_r;

endmodule

// File: tb/tb_blinker_core.sv
// Directed self-checking bench for blinker_core (NUM_LEDS = 8).
module tb_blinker_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ctrl_reg;
    logic [31:0] period_reg;
    logic [31:0] pattern_reg;
    logic [31:0] count_reg;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [7:0]  leds;
    logic        step_tick;
    logic [31:0] status;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    blinker_core #(.C_S00_AXI_DATA_WIDTH(32), .NUM_LEDS(8)) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .ctrl_reg       (ctrl_reg),
        .period_reg     (period_reg),
        .pattern_reg    (pattern_reg),
        .count_reg      (count_reg),
        .cfg_wr         (cfg_wr),
        .cfg_addr       (cfg_addr),
        .leds           (leds),
        .step_tick      (step_tick),
        .status         (status)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] rot_exp [8];
    logic [7:0] prev;
    logic       any_tick;
    logic       all_tick;

    initial begin
        rot_exp[0] = 8'h02; rot_exp[1] = 8'h04; rot_exp[2] = 8'h08; rot_exp[3] = 8'h10;
        rot_exp[4] = 8'h20; rot_exp[5] = 8'h40; rot_exp[6] = 8'h80; rot_exp[7] = 8'h01;

        rst_n = 1'b0; ctrl_reg = 32'd0; period_reg = 32'd0; pattern_reg = 32'd0;
        count_reg = 32'd0; cfg_wr = 1'b0; cfg_addr = 2'd0;
        cyc(3);
        chk_eq("rst_leds",   32'(leds),      32'h0);
        chk_eq("rst_status", status,         32'h0);
        chk_eq("rst_tick",   32'(step_tick), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Reset asserted mid-run, enable kept high across release
        period_reg = 32'd1; pattern_reg = 32'h01; ctrl_reg = 32'h1;
        cyc(6);
        #3 rst_n = 1'b0;
        #1;
        chk_eq("arst_leds",   32'(leds),      32'h0);
        chk_eq("arst_status", status,         32'h0);
        chk_eq("arst_tick",   32'(step_tick), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk_eq("post_rst_status", status,    32'h0);
        chk_eq("post_rst_leds",   32'(leds), 32'h0);
        ctrl_reg = 32'h0; cyc(1);
        ctrl_reg = 32'h1; cyc(3);
        chk_eq("rerun_state", status & 32'h3, 32'h1);
        ctrl_reg = 32'h0; cyc(3);

        // Free run, period 4, rotate left from 0x01
        period_reg = 32'd4; pattern_reg = 32'h01; ctrl_reg = 32'h1;
        cyc(1);
        cyc(1);
        chk_eq("free_first", 32'(leds), 32'h01);
        for (int k = 0; k < 8; k++) begin
            cyc(3);
            chk_eq("free_tick", 32'(step_tick), 32'h1);
            cyc(1);
            chk_eq("free_leds", 32'(leds), 32'(rot_exp[k]));
            chk_eq("free_notick", 32'(step_tick), 32'h0);
        end
        chk_eq("free_status", status, 32'h0008_0001);
        ctrl_reg = 32'h0; cyc(2);
        chk_eq("free_off_leds",   32'(leds), 32'h0);
        chk_eq("free_off_status", status,    32'h0);
        cyc(1);

        // One-shot, 3 steps of period 2 from 0x81
        count_reg = 32'd3; period_reg = 32'd2; pattern_reg = 32'h81; ctrl_reg = 32'h3;
        cyc(12);
        chk_eq("os_leds",   32'(leds), 32'h0C);
        chk_eq("os_status", status,    32'h0003_0007);
        any_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            any_tick = any_tick | step_tick;
        end
        chk_eq("os_no_tick", 32'(any_tick), 32'h0);
        ctrl_reg = 32'h0; cyc(2);
        chk_eq("os_off_status", status,    32'h0);
        chk_eq("os_off_leds",   32'(leds), 32'h0);
        ctrl_reg = 32'h3; cyc(12);
        chk_eq("os2_leds",   32'(leds), 32'h0C);
        chk_eq("os2_status", status,    32'h0003_0007);
        ctrl_reg = 32'h0; cyc(3);

        // Period 0 steps every cycle
        period_reg = 32'd0; pattern_reg = 32'h01; ctrl_reg = 32'h1;
        cyc(1);
        all_tick = 1'b1;
        cyc(1); all_tick = all_tick & step_tick;
        cyc(1); all_tick = all_tick & step_tick;
        chk_eq("p0_leds1", 32'(leds), 32'h02);
        cyc(1); all_tick = all_tick & step_tick;
        chk_eq("p0_leds2", 32'(leds), 32'h04);
        chk_eq("p0_ticks", 32'(all_tick), 32'h1);
        ctrl_reg = 32'h0; cyc(3);

        // One-shot with count 0 finishes without a step
        period_reg = 32'd1; count_reg = 32'd0; pattern_reg = 32'h01; ctrl_reg = 32'h3;
        any_tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            any_tick = any_tick | step_tick;
        end
        chk_eq("c0_status",  status,        32'h0000_0007);
        chk_eq("c0_no_tick", 32'(any_tick), 32'h0);
        ctrl_reg = 32'h0; cyc(3);

        // Invert
        period_reg = 32'd1000; pattern_reg = 32'h0F; ctrl_reg = 32'h5;
        cyc(3);
        chk_eq("inv_leds", 32'(leds), 32'hF0);
        ctrl_reg = 32'h0; cyc(3);

        // Rotate right
        period_reg = 32'd2; pattern_reg = 32'h01; ctrl_reg = 32'h9;
        cyc(4);
        chk_eq("dir_leds1", 32'(leds), 32'h80);
        cyc(2);
        chk_eq("dir_leds2", 32'(leds), 32'h40);
        ctrl_reg = 32'h0; cyc(3);

        // Pattern write whose reload lands on a step-due cycle
        period_reg = 32'd4; pattern_reg = 32'h01; ctrl_reg = 32'h1;
        cyc(1);
        cyc(2);
        cfg_wr = 1'b1; cfg_addr = 2'd2; pattern_reg = 32'h55;
        cyc(1);
        cfg_wr = 1'b0; cfg_addr = 2'd0;
        cyc(1);
        chk_eq("rl_suppressed", 32'(step_tick), 32'h0);
        cyc(1);
        chk_eq("rl_leds", 32'(leds), 32'h55);
        cyc(2);
        chk_eq("rl_wait", 32'(step_tick), 32'h0);
        cyc(1);
        chk_eq("rl_tick", 32'(step_tick), 32'h1);
        cyc(1);
        chk_eq("rl_rot",    32'(leds), 32'hAA);
        chk_eq("rl_status", status,    32'h0001_0001);
        ctrl_reg = 32'h0; cyc(3);

        // Long run: steps saturate while leds keep rotating
        period_reg = 32'd1; pattern_reg = 32'h01; ctrl_reg = 32'h1;
        cyc(70000);
        chk_eq("sat_steps", status >> 16, 32'h0000_FFFF);
        prev = leds;
        cyc(1);
        chk_eq("sat_rot",  32'(leds), 32'({prev[6:0], prev[7]}));
        chk_eq("sat_tick", 32'(step_tick), 32'h1);
        ctrl_reg = 32'h0; cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/blinker_core.md
Name: blinker_core

Overview:
- Sequencing engine of the blinker IP. Sits directly downstream of the 4-register AXI4-Lite slave, inside the blinker_ip_v1_0 top.
- Consumes slv_reg0..3 plus the slave's write strobe. Steps a rotating LED pattern at a programmable rate and returns a status word for read-back.
- Supports free-running mode and one-shot mode (fixed step count).

Parameters:
- C_S00_AXI_DATA_WIDTH, 32: width of register inputs and the status output.
- NUM_LEDS, 8: LED output width; range 1..32.

Ports:
- s00_axi_aclk  in  1  sole clock
- s00_axi_aresetn  in  1  asynchronous, active-low reset
- ctrl_reg  in  32  slv_reg0: [0] enable, [1] one_shot, [2] invert, [3] dir (0 = rotate left, 1 = rotate right)
- period_reg  in  32  slv_reg1: clock ticks per step; 0 is treated as 1
- pattern_reg  in  32  slv_reg2: [NUM_LEDS-1:0] seed pattern
- count_reg  in  32  slv_reg3: steps per one-shot run; 0 means DONE immediately
- cfg_wr  in  1  one-cycle pulse, slave register write accepted (slv_reg_wren)
- cfg_addr  in  2  register index of that write
- leds  out  NUM_LEDS  LED drive
- step_tick  out  1  one-cycle pulse on every pattern step
- status  out  32  [1:0] state, [2] done, [15:3] zero, [31:16] steps taken (saturating)

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; leds = 0; step_tick = 0; status = 0.
  - Prescaler, step counter and pattern register are cleared.
- Register inputs are already synchronous; the core samples them every cycle.
- Enable rising edge: detected against a registered copy of ctrl_reg[0].
- States (status encoding):
  - IDLE(0): leds = 0.
    - Enable rising edge in cycle N → RUN in N+1.
    - On entry to RUN: pattern loaded from pattern_reg, prescaler = 0, steps = 0.
  - RUN(1):
    - Prescaler increments each cycle. When prescaler == max(period_reg,1)-1: prescaler → 0, pattern rotates one place per dir, step_tick = 1 for that cycle, steps + 1.
    - First step occurs at N+1+P (P = effective period).
    - one_shot = 1 and steps reaching count_reg → DONE in the same cycle as the final step.
    - one_shot = 1 with count_reg = 0 → DONE in N+2 with no step.
  - DONE(3): leds hold the last pattern; done = 1; no ticks. Enable low → IDLE next cycle. A new run requires a fresh rising edge.
  - State code 2 is reserved and never entered. If ever decoded, the core returns to IDLE.
- Enable low while in RUN → IDLE next cycle; leds = 0; counters cleared.
- cfg_wr with cfg_addr = 2 while in RUN:
  - Pattern reloads from pattern_reg one cycle after the strobe; prescaler → 0; steps unchanged.
  - A step due in that same cycle is suppressed; the reload wins.
- cfg_wr with cfg_addr = 1 while in RUN: prescaler → 0 so the new period applies cleanly.
- Changing one_shot or count_reg mid-run takes effect at the next step compare.
- Reducing count_reg below steps mid-run ends the run at the next step.
- leds = pattern XOR {NUM_LEDS{invert}} in RUN/DONE, and 0 in IDLE. leds is registered: one cycle behind the pattern register. invert does not apply in IDLE.
- steps saturates at 16'hFFFF and never wraps. The prescaler is 32-bit, so a period of 2^32-1 is legal.
- Outputs are glitch-free registers; no combinational path from inputs to outputs.

Decomposition:
- Package blinker_pkg:
  - state enum (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3)
  - ctrl bit-index constants (CTRL_EN = 0, CTRL_ONESHOT = 1, CTRL_INV = 2, CTRL_DIR = 3)
  - register index constants (REG_CTRL..REG_COUNT)
  - status field offsets
- One sub-module: blinker_prescaler. Inputs: period, clear, run. Output: tick. Handles period = 0 → 1.
- Pattern rotation, the FSM and status assembly stay in blinker_core.

Test Plan:
1. Reset mid-RUN → async clear: leds = 0 and status = 0 immediately; after release, state remains IDLE with enable held high until a fresh rising edge.
2. Free-run, NUM_LEDS = 8:
   - Setup: period = 4, pattern = 0x01, dir = 0; ctrl = 0x1 written.
   - Required: leds = 0x01, then 0x02 four cycles later, 0x04, …; 0x80 wraps to 0x01.
   - step_tick pulses every 4 cycles; status[31:16] counts up.
3. One-shot: ctrl = 0x3, count = 3, period = 2, pattern = 0x81 → leds end at 0x0C; status = {16'd3, 13'd0, done = 1, state = 3}; no further ticks. ctrl = 0 then 0x3 → rerun.
4. Boundaries:
   - period = 0 → a step every cycle.
   - count = 0 one-shot → DONE with steps = 0.
   - invert = 1, pattern 0x0F → leds = 0xF0.
   - dir = 1, 0x01 → 0x80.
5. Mid-run pattern write 0x55 coinciding with a step cycle → no rotation that cycle; leds = 0x55 next cycle; prescaler restarts.
6. Long run with period = 1 for 70000 cycles → steps saturates at 0xFFFF; leds keep rotating.
